// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package addsub_pkg;

    // Controller states
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Counter width large enough to hold WIDTH/DIGIT
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry slice shared by every step of the serial adder.
module digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_top
);

    // Ripple the carry across the slice; also expose the carry into the top bit
    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout  = c[DIGIT];
        c_top = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_adder_subtractor
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic             slice_c_top;
    logic [WIDTH-1:0] result;
    logic             load;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c_top(slice_c_top)
    );

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
`else
    logic unused_c_top;
    assign unused_c_top = slice_c_top;
`endif

    // Next-state: controller, operand shifters, result accumulator and counter
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        load    = 1'b0;
        // New digit enters from the MSB side; stale low digit falls off
        result  = (acc_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

        unique case (state_q)
            StIdle: begin
                if (start) load = 1'b1;
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = result;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                    sum_d   = result;
                    cout_d  = slice_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = slice_c_top ^ slice_cout;
`endif
                end
            end
            StDone: begin
                if (start) load = 1'b1;
                else       state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Subtraction is a + ~b + 1: invert b and seed the carry with mode
        if (load) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{mode}};
            carry_d = mode;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor (WIDTH=8, DIGIT=2).
module tb_serial_adder_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int checks;
    int failures;

    serial_adder_subtractor #(
        .WIDTH(8),
        .DIGIT(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .mode (mode),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;   // expected ovf when the overflow feature is built in
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_ADDSUB_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Waits for done from the negedge after the accepting edge; bounded
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 12) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic mi,
                         output int lat, output int bcnt);
        @(negedge clk);
        a = ai; b = bi; mode = mi; start = 1'b1;
        @(negedge clk);
        // operands are free to change once captured
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        mode = 1'($urandom);
        wait_done(lat, bcnt);
    endtask

    vec_t vecs[7];
    int   lat;
    int   bcnt;
    int   dcnt;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;

        vecs[0] = '{8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h09, 8'h07, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].mode, lat, bcnt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd4);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(exp_ovf(vecs[i].ovf)));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_sum_held", i), 32'(sum), 32'(vecs[i].sum));
        end

        // start during RUN is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; mode = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        @(negedge clk);                       // after E1
        a = 8'h55; b = 8'h11; mode = 1'b1; start = 1'b1;
        @(negedge clk);                       // after E2
        start = 1'b0;
        chk("ign_busy_mid", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        chk("ign_latency_rest", 32'(lat), 32'd2);
        chk("ign_sum", 32'(sum), 32'h30);
        chk("ign_cout", 32'(cout), 32'd0);
        @(negedge clk);
        chk("ign_not_requeued", 32'(busy | done), 32'd0);

        // reset aborts an operation in progress
        @(negedge clk);
        a = 8'h33; b = 8'h44; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("rst_no_resume", 32'(dcnt), 32'd0);

        // rst wins over start on the same edge
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_priority", 32'(busy), 32'd0);

        // back-to-back: start held through DONE
        @(negedge clk);
        a = 8'h01; b = 8'h02; mode = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0
        a = 8'h0A; b = 8'h03; mode = 1'b1;
        wait_done(lat, bcnt);
        chk("b2b_first_latency", 32'(lat), 32'd4);
        chk("b2b_first_sum", 32'(sum), 32'h03);
        @(negedge clk);                       // next edge accepted the second op
        start = 1'b0;
        a = 8'hFF; b = 8'hFF; mode = 1'b0;
        chk("b2b_no_idle_busy", 32'(busy), 32'd1);
        chk("b2b_no_idle_done", 32'(done), 32'd0);
        chk("b2b_sum_held", 32'(sum), 32'h03);
        wait_done(lat, bcnt);
        chk("b2b_second_latency", 32'(lat), 32'd4);
        chk("b2b_second_sum", 32'(sum), 32'h07);
        chk("b2b_second_cout", 32'(cout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_subtractor.md
# serial_adder_subtractor

Parametrised, multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock through one shared DIGIT-bit ripple slice. It is the sequential successor to the 4-bit combinational adder/subtractor and trades latency for area. The datapath controller drives it with a start/busy/done handshake.

## Interface
- WIDTH, 8: operand and result width; must be a multiple of DIGIT.
- DIGIT, 2: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  first operand; captured on the accepting edge.
- b  input  WIDTH  second operand; captured on the accepting edge.
- mode  input  1  0 = a+b, 1 = a−b (two's complement); captured with operands.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out; in subtract mode, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow (see Configuration).

## Operation
- N = WIDTH/DIGIT digit steps.
- States:
  - IDLE: start=1 → load a, b^{WIDTH{mode}}, carry=mode, digit counter=0 → RUN.
  - RUN: each edge adds the lowest DIGIT bits of the operand registers plus carry; shifts the result digit into sum from the MSB side; shifts operands right by DIGIT; increments the counter. After the N-th step → DONE.
  - DONE: done=1 for exactly one cycle. start=1 → load (as in IDLE) → RUN; otherwise → IDLE.
- Arithmetic: sum = (a + (b XOR mode-mask) + mode) mod 2^WIDTH. cout = final slice carry.
- sum, cout and ovf update only at the DONE transition. Intermediate values are held internally and never appear on outputs.
- start in RUN is ignored and not queued.
- Inputs a, b and mode may change freely after the accepting edge.
- Reset mid-operation aborts the operation. Next state is IDLE with all outputs cleared.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE.
- Accepting edge E0 → busy=1 from E0 through EN−1.
- EN: busy=0, done=1, result valid.
- Latency is N cycles from the accepting edge to done. With defaults N=4.
- Back-to-back: start held high during DONE gives throughput of one result per N+1 cycles.
- rst has priority over start on the same edge.

## Configuration
- SERIAL_ADDSUB_OVF_EN:
  - Defined: ovf = carry into MSB XOR carry out of MSB, registered with sum.
  - Undefined: ovf tied to 0. No overflow logic is synthesised; the port remains.

## Structure
- Shared package addsub_pkg holds:
  - state typedef (IDLE, RUN, DONE)
  - localparam helper for counter width, $clog2(WIDTH/DIGIT+1)
- Sub-module digit_adder: DIGIT-bit ripple slice.
  - Inputs: x, y, cin. Outputs: s, cout, and carry into the top bit (for ovf).
  - Instantiated once.
- The controller, shift registers and counter live in the top module.

## Test plan
All scenarios use WIDTH=8, DIGIT=2.
- a=0x05, b=0x06, mode=0, start pulse → done exactly 4 cycles after the accepting edge; sum=0x0B, cout=0, busy high for 4 cycles.
- a=0xFF, b=0x01, mode=0 → sum=0x00, cout=1, ovf=0.
- a=0x09, b=0x07, mode=1 → sum=0x02, cout=1.
- a=0x03, b=0x05, mode=1 → sum=0xFE, cout=0.
- a=0x7F, b=0x01, mode=0 → sum=0x80, ovf=1 with SERIAL_ADDSUB_OVF_EN, ovf=0 without.
- Start at E0 with a=0x10, b=0x20; start again at E2 with other operands → ignored, sum=0x30. Then rst asserted mid-run of a new operation → next cycle busy=0, done=0, sum=0. Then start held through DONE → second operation begins with no IDLE cycle.
